ps2_hex_entry_ctrl: RTL and testbench
=====================================

// Module: ps2_hex_entry_ctrl
// PURPOSE
//  Sequences PS/2 keyboard input into AES operands. Decodes make/break scan codes
//  from the PS/2 interface and assembles hex digits into a 128-bit key, then a
//  128-bit plaintext. On Enter it launches the AES core through a start/ready/done
//  handshake. Sits between PS2_Interface and the AES core; entry_buf/digit_count
//  feed the LCD and seven-segment displays.
// PARAMETERS
//  NIBBLES     32     hex digits per operand; operand width W = 4*NIBBLES
//  BREAK_CODE  8'hF0  PS/2 break prefix
//  EXT_CODE    8'hE0  PS/2 extended prefix
// PORTS
//  clock        in   1   system clock
//  reset        in   1   synchronous, active-high
//  key_data     in   8   scan code byte from PS2_Interface
//  key_valid    in   1   one-cycle strobe, key_data valid
//  aes_ready    in   1   AES core idle, may accept start
//  aes_done     in   1   one-cycle pulse, AES result valid
//  aes_start    out  1   one-cycle launch pulse
//  key_out      out  W   committed key
//  text_out     out  W   committed plaintext
//  entry_buf    out  W   digits being typed, newest in [3:0]
//  digit_count  out  6   digits in entry_buf, 0..NIBBLES
//  phase        out  2   0 ENTER_KEY, 1 ENTER_TEXT, 2 LAUNCH, 3 RUN
//  entry_err    out  1   one-cycle pulse on rejected command
// BEHAVIOUR
//  Reset: every output 0; phase=ENTER_KEY; decoder=D_MAKE.
//  All outputs registered. Effect of a key_valid byte is visible the next cycle.
//  Decoder FSM (advances on key_valid in every phase):
//   D_MAKE: F0->D_BREAK; E0->D_EXT; otherwise emit make event.
//   D_EXT: F0->D_BREAK; other byte discarded ->D_MAKE.
//   D_BREAK: byte discarded ->D_MAKE. Releases are never digits.
//  Make map: 45,16,1E,26,25,2E,36,3D,3E,46 = 0-9; 1C,32,21,23,24,2B = A-F;
//   5A Enter; 66 Backspace; 76 Esc; all others ignored.
//  Make events act only in ENTER_KEY and ENTER_TEXT:
//   Digit: if count<NIBBLES, buf<={buf[W-5:0],nib} and count+1. Else entry_err.
//   Backspace: if count>0, buf<=buf>>4 and count-1. Else entry_err.
//   Esc: clears buf and count. In ENTER_TEXT with count==0, goes to ENTER_KEY.
//   Enter with count!=NIBBLES: entry_err, no other change.
//   Enter with count==NIBBLES:
//    In ENTER_KEY: key_out<=buf, clear buf and count, go to ENTER_TEXT.
//    In ENTER_TEXT: text_out<=buf, clear buf and count, go to LAUNCH.
//  LAUNCH: first cycle aes_ready is sampled 1, aes_start=1 for exactly one cycle
//   and phase goes to RUN. aes_start is never high outside that cycle.
//  RUN: wait for aes_done, then go to ENTER_TEXT. key_out is kept, so the next
//   plaintext reuses the key.
//  In LAUNCH and RUN, make events are ignored. They do not raise entry_err.
//  If aes_done and key_valid arrive in the same cycle in RUN: the decoder state
//   still updates, the byte is not entered, and phase goes to ENTER_TEXT.
//  key_out and text_out change only on a successful Enter commit.
//  Reset mid-entry or mid-RUN returns everything to reset values at the next edge.
// TESTING
//  1. Send 1C,F0,1C -> entry_buf=0xA, count=1. The break byte adds no digit.
//  2. Type 32 digits "2B7E1516..."+5A -> key_out=2B7E1516..., phase=1, count=0.
//  3. Type 31 digits then 5A -> entry_err pulse. Type a 33rd digit -> entry_err,
//     buf unchanged.
//  4. With count=3, buf=0xABC, send 66 -> buf=0xAB, count=2. Backspace at count=0
//     -> entry_err.
//  5. Commit 32-digit text with aes_ready=0 for 5 cycles -> aes_start held 0. Then
//     raise aes_ready -> one aes_start pulse, phase=3. Pulse aes_done -> phase=1.
//  6. Send E0,F0,75 -> nothing entered, decoder back to D_MAKE. Assert reset
//     during RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ps2_hex_entry_ctrl.sv
// ps2_hex_entry_ctrl
//  Turns PS/2 scan-code bytes into AES operands. A small decoder FSM strips
//  break (F0) and extended (E0) sequences so that only key presses become make
//  events. Make events build a hex string in entry_buf. Enter commits that
//  string first as the key and then as the plaintext. The block then starts
//  the AES core and waits for it to finish. After a run it returns to
//  plaintext entry and keeps the key.
//
// Ports
//  clock        system clock
//  reset        synchronous, active-high
//  key_data     scan code byte from the PS/2 interface
//  key_valid    one-cycle strobe qualifying key_data
//  aes_ready    AES core idle and able to accept a start
//  aes_done     one-cycle pulse, AES result valid
//  aes_start    one-cycle launch pulse to the AES core
//  key_out      committed key
//  text_out     committed plaintext
//  entry_buf    digits being typed, newest digit in [3:0]
//  digit_count  number of digits held in entry_buf
//  phase        0 enter key, 1 enter text, 2 launch, 3 run
//  entry_err    one-cycle pulse when a command is rejected
module ps2_hex_entry_ctrl #(
    parameter int         NIBBLES    = 32,
    parameter logic [7:0] BREAK_CODE = 8'hF0,
    parameter logic [7:0] EXT_CODE   = 8'hE0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [7:0]             key_data,
    input  logic                   key_valid,
    input  logic                   aes_ready,
    input  logic                   aes_done,
    output logic                   aes_start,
    output logic [4*NIBBLES-1:0]   key_out,
    output logic [4*NIBBLES-1:0]   text_out,
    output logic [4*NIBBLES-1:0]   entry_buf,
    output logic [5:0]             digit_count,
    output logic [1:0]             phase,
    output logic                   entry_err
);

    localparam int         W          = 4 * NIBBLES;
    localparam logic [5:0] FULL_COUNT = 6'(NIBBLES);

    typedef enum logic [1:0] {
        D_MAKE  = 2'd0,
        D_EXT   = 2'd1,
        D_BREAK = 2'd2
    } dec_state_t;

    typedef enum logic [1:0] {
        ENTER_KEY  = 2'd0,
        ENTER_TEXT = 2'd1,
        LAUNCH     = 2'd2,
        RUN        = 2'd3
    } phase_t;

    dec_state_t   dec_q, dec_n;
    phase_t       phase_q, phase_n;
    logic [W-1:0] key_n, text_n, buf_n;
    logic [5:0]   count_n;
    logic         start_n, err_n;

    logic         is_digit, is_enter, is_bksp, is_esc;
    logic [3:0]   nib;
    logic         make_event;

    assign phase = phase_q;

    // Scan code map for keys that carry a meaning. All other codes are ignored.
    always_comb begin
        is_digit = 1'b0;
        is_enter = 1'b0;
        is_bksp  = 1'b0;
        is_esc   = 1'b0;
        nib      = 4'h0;
        case (key_data)
            8'h45: begin is_digit = 1'b1; nib = 4'h0; end
            8'h16: begin is_digit = 1'b1; nib = 4'h1; end
            8'h1E: begin is_digit = 1'b1; nib = 4'h2; end
            8'h26: begin is_digit = 1'b1; nib = 4'h3; end
            8'h25: begin is_digit = 1'b1; nib = 4'h4; end
            8'h2E: begin is_digit = 1'b1; nib = 4'h5; end
            8'h36: begin is_digit = 1'b1; nib = 4'h6; end
            8'h3D: begin is_digit = 1'b1; nib = 4'h7; end
            8'h3E: begin is_digit = 1'b1; nib = 4'h8; end
            8'h46: begin is_digit = 1'b1; nib = 4'h9; end
            8'h1C: begin is_digit = 1'b1; nib = 4'hA; end
            8'h32: begin is_digit = 1'b1; nib = 4'hB; end
            8'h21: begin is_digit = 1'b1; nib = 4'hC; end
            8'h23: begin is_digit = 1'b1; nib = 4'hD; end
            8'h24: begin is_digit = 1'b1; nib = 4'hE; end
            8'h2B: begin is_digit = 1'b1; nib = 4'hF; end
            8'h5A: is_enter = 1'b1;
            8'h66: is_bksp  = 1'b1;
            8'h76: is_esc   = 1'b1;
            default: ;
        endcase
    end

    // A byte is a key press only when no prefix is pending and the byte is
    // not itself a prefix.
    assign make_event = key_valid && (dec_q == D_MAKE) &&
                        (key_data != BREAK_CODE) && (key_data != EXT_CODE);

    // Decoder next state. It advances in every phase, so prefixes received
    // while AES is running are still tracked.
    always_comb begin
        dec_n = dec_q;
        if (key_valid) begin
            case (dec_q)
                D_MAKE: begin
                    if (key_data == BREAK_CODE)
                        dec_n = D_BREAK;
                    else if (key_data == EXT_CODE)
                        dec_n = D_EXT;
                end
                D_EXT: begin
                    if (key_data == BREAK_CODE)
                        dec_n = D_BREAK;
                    else
                        dec_n = D_MAKE;
                end
                default: dec_n = D_MAKE;
            endcase
        end
    end

    // Phase sequencing and entry editing. Every output is computed here and
    // registered below.
    always_comb begin
        phase_n = phase_q;
        key_n   = key_out;
        text_n  = text_out;
        buf_n   = entry_buf;
        count_n = digit_count;
        start_n = 1'b0;
        err_n   = 1'b0;
        case (phase_q)
            ENTER_KEY, ENTER_TEXT: begin
                if (make_event) begin
                    if (is_digit) begin
                        if (digit_count < FULL_COUNT) begin
                            buf_n   = {entry_buf[W-5:0], nib};
                            count_n = digit_count + 6'd1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else if (is_bksp) begin
                        if (digit_count != 6'd0) begin
                            buf_n   = entry_buf >> 4;
                            count_n = digit_count - 6'd1;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else if (is_esc) begin
                        // A second Esc on an empty plaintext backs out to key entry.
                        buf_n   = '0;
                        count_n = 6'd0;
                        if (phase_q == ENTER_TEXT && digit_count == 6'd0)
                            phase_n = ENTER_KEY;
                    end else if (is_enter) begin
                        if (digit_count != FULL_COUNT) begin
                            err_n = 1'b1;
                        end else begin
                            buf_n   = '0;
                            count_n = 6'd0;
                            if (phase_q == ENTER_KEY) begin
                                key_n   = entry_buf;
                                phase_n = ENTER_TEXT;
                            end else begin
                                text_n  = entry_buf;
                                phase_n = LAUNCH;
                            end
                        end
                    end
                end
            end
            LAUNCH: begin
                if (aes_ready) begin
                    start_n = 1'b1;
                    phase_n = RUN;
                end
            end
            default: begin
                if (aes_done)
                    phase_n = ENTER_TEXT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dec_q       <= D_MAKE;
            phase_q     <= ENTER_KEY;
            key_out     <= '0;
            text_out    <= '0;
            entry_buf   <= '0;
            digit_count <= 6'd0;
            aes_start   <= 1'b0;
            entry_err   <= 1'b0;
        end else begin
            dec_q       <= dec_n;
            phase_q     <= phase_n;
            key_out     <= key_n;
            text_out    <= text_n;
            entry_buf   <= buf_n;
            digit_count <= count_n;
            aes_start   <= start_n;
            entry_err   <= err_n;
        end
    end

endmodule

// File: tb/tb_ps2_hex_entry_ctrl.sv
// tb_ps2_hex_entry_ctrl
//  Directed bench for ps2_hex_entry_ctrl. A vector table covers decoder
//  prefixes and single-key editing from reset. Hand-written sequences cover
//  full operand entry, overflow, the launch handshake, and reset during a run.
module tb_ps2_hex_entry_ctrl;

    logic         clock;
    logic         reset;
    logic [7:0]   key_data;
    logic         key_valid;
    logic         aes_ready;
    logic         aes_done;
    logic         aes_start;
    logic [127:0] key_out;
    logic [127:0] text_out;
    logic [127:0] entry_buf;
    logic [5:0]   digit_count;
    logic [1:0]   phase;
    logic         entry_err;

    int checks = 0;
    int errors = 0;
    int start_pulses = 0;

    localparam logic [127:0] KEY  = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] TEXT = 128'h3243F6A8885A308D313198A2E0370734;

    logic [7:0] scan_of [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

    typedef struct {
        logic [7:0]   code;
        logic [127:0] exp_buf;
        logic [5:0]   exp_count;
        logic [1:0]   exp_phase;
        logic         exp_err;
    } vec_t;

    vec_t vecs [20];

    ps2_hex_entry_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .key_data    (key_data),
        .key_valid   (key_valid),
        .aes_ready   (aes_ready),
        .aes_done    (aes_done),
        .aes_start   (aes_start),
        .key_out     (key_out),
        .text_out    (text_out),
        .entry_buf   (entry_buf),
        .digit_count (digit_count),
        .phase       (phase),
        .entry_err   (entry_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (aes_start)
            start_pulses++;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one scan byte for exactly one cycle. Return 1 time unit after the
    // edge that consumed it.
    task automatic applyStimulus(input logic [7:0] code);
        @(negedge clock);
        key_data  = code;
        key_valid = 1'b1;
        @(posedge clock);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic typeOperand(input logic [127:0] val, input int n);
        logic [3:0] d;
        for (int i = 0; i < n; i++) begin
            d = val[127-4*i -: 4];
            applyStimulus(scan_of[d]);
        end
    endtask

    initial begin
        vecs[0]  = '{8'h1C, 128'hA,   6'd1, 2'd0, 1'b0};
        vecs[1]  = '{8'hF0, 128'hA,   6'd1, 2'd0, 1'b0};
        vecs[2]  = '{8'h1C, 128'hA,   6'd1, 2'd0, 1'b0};
        vecs[3]  = '{8'h32, 128'hAB,  6'd2, 2'd0, 1'b0};
        vecs[4]  = '{8'h21, 128'hABC, 6'd3, 2'd0, 1'b0};
        vecs[5]  = '{8'h66, 128'hAB,  6'd2, 2'd0, 1'b0};
        vecs[6]  = '{8'h66, 128'hA,   6'd1, 2'd0, 1'b0};
        vecs[7]  = '{8'h66, 128'h0,   6'd0, 2'd0, 1'b0};
        vecs[8]  = '{8'h66, 128'h0,   6'd0, 2'd0, 1'b1};
        vecs[9]  = '{8'hE0, 128'h0,   6'd0, 2'd0, 1'b0};
        vecs[10] = '{8'hF0, 128'h0,   6'd0, 2'd0, 1'b0};
        vecs[11] = '{8'h75, 128'h0,   6'd0, 2'd0, 1'b0};
        vecs[12] = '{8'h16, 128'h1,   6'd1, 2'd0, 1'b0};
        vecs[13] = '{8'h76, 128'h0,   6'd0, 2'd0, 1'b0};
        vecs[14] = '{8'h5A, 128'h0,   6'd0, 2'd0, 1'b1};
        vecs[15] = '{8'hE0, 128'h0,   6'd0, 2'd0, 1'b0};
        vecs[16] = '{8'h16, 128'h0,   6'd0, 2'd0, 1'b0};
        vecs[17] = '{8'h16, 128'h1,   6'd1, 2'd0, 1'b0};
        vecs[18] = '{8'h76, 128'h0,   6'd0, 2'd0, 1'b0};
        vecs[19] = '{8'h4D, 128'h0,   6'd0, 2'd0, 1'b0};

        reset     = 1'b1;
        key_data  = 8'h00;
        key_valid = 1'b0;
        aes_ready = 1'b0;
        aes_done  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset key_out", key_out, 128'h0);
        checkOutput("reset text_out", text_out, 128'h0);
        checkOutput("reset entry_buf", entry_buf, 128'h0);
        checkOutput("reset count", 128'(digit_count), 128'h0);
        checkOutput("reset phase", 128'(phase), 128'h0);
        checkOutput("reset aes_start", 128'(aes_start), 128'h0);
        checkOutput("reset entry_err", 128'(entry_err), 128'h0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] vector table");
        for (int v = 0; v < 20; v++) begin
            applyStimulus(vecs[v].code);
            checkOutput($sformatf("vec%0d buf", v), entry_buf, vecs[v].exp_buf);
            checkOutput($sformatf("vec%0d count", v), 128'(digit_count), 128'(vecs[v].exp_count));
            checkOutput($sformatf("vec%0d phase", v), 128'(phase), 128'(vecs[v].exp_phase));
            checkOutput($sformatf("vec%0d err", v), 128'(entry_err), 128'(vecs[v].exp_err));
        end

        $display("[TB] key entry");
        typeOperand(KEY, 32);
        checkOutput("key full buf", entry_buf, KEY);
        checkOutput("key full count", 128'(digit_count), 128'd32);
        applyStimulus(8'h5A);
        checkOutput("key commit key_out", key_out, KEY);
        checkOutput("key commit phase", 128'(phase), 128'd1);
        checkOutput("key commit count", 128'(digit_count), 128'd0);
        checkOutput("key commit buf", entry_buf, 128'h0);
        checkOutput("key commit text_out", text_out, 128'h0);

        $display("[TB] text entry and overflow");
        typeOperand(TEXT, 31);
        checkOutput("text31 buf", entry_buf, TEXT >> 4);
        checkOutput("text31 count", 128'(digit_count), 128'd31);
        applyStimulus(8'h5A);
        checkOutput("short enter err", 128'(entry_err), 128'd1);
        checkOutput("short enter phase", 128'(phase), 128'd1);
        checkOutput("short enter count", 128'(digit_count), 128'd31);
        applyStimulus(scan_of[TEXT[3:0]]);
        checkOutput("text32 buf", entry_buf, TEXT);
        checkOutput("text32 err", 128'(entry_err), 128'd0);
        applyStimulus(8'h2B);
        checkOutput("overflow err", 128'(entry_err), 128'd1);
        checkOutput("overflow buf", entry_buf, TEXT);
        checkOutput("overflow count", 128'(digit_count), 128'd32);
        applyStimulus(8'h5A);
        checkOutput("text commit text_out", text_out, TEXT);
        checkOutput("text commit key_out", key_out, KEY);
        checkOutput("text commit phase", 128'(phase), 128'd2);
        checkOutput("text commit count", 128'(digit_count), 128'd0);

        $display("[TB] launch handshake");
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            checkOutput($sformatf("wait%0d start", c), 128'(aes_start), 128'd0);
            checkOutput($sformatf("wait%0d phase", c), 128'(phase), 128'd2);
        end
        @(negedge clock);
        aes_ready = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("launch start", 128'(aes_start), 128'd1);
        checkOutput("launch phase", 128'(phase), 128'd3);
        @(posedge clock);
        #1;
        checkOutput("run start low", 128'(aes_start), 128'd0);
        checkOutput("run phase", 128'(phase), 128'd3);
        applyStimulus(8'h16);
        checkOutput("run key count", 128'(digit_count), 128'd0);
        checkOutput("run key err", 128'(entry_err), 128'd0);
        checkOutput("run key phase", 128'(phase), 128'd3);

        @(negedge clock);
        key_data  = 8'hF0;
        key_valid = 1'b1;
        aes_done  = 1'b1;
        @(posedge clock);
        #1;
        key_valid = 1'b0;
        aes_done  = 1'b0;
        checkOutput("done phase", 128'(phase), 128'd1);
        checkOutput("done count", 128'(digit_count), 128'd0);
        checkOutput("done key_out", key_out, KEY);
        checkOutput("done text_out", text_out, TEXT);
        applyStimulus(8'h1C);
        checkOutput("post-done break count", 128'(digit_count), 128'd0);
        applyStimulus(8'h1C);
        checkOutput("post-done digit buf", entry_buf, 128'hA);
        checkOutput("post-done digit count", 128'(digit_count), 128'd1);

        $display("[TB] escape back to key entry");
        applyStimulus(8'h76);
        checkOutput("esc1 count", 128'(digit_count), 128'd0);
        checkOutput("esc1 phase", 128'(phase), 128'd1);
        applyStimulus(8'h76);
        checkOutput("esc2 phase", 128'(phase), 128'd0);
        checkOutput("esc2 key_out", key_out, KEY);

        $display("[TB] reset during run");
        typeOperand(KEY, 32);
        applyStimulus(8'h5A);
        typeOperand(TEXT, 32);
        applyStimulus(8'h5A);
        checkOutput("relaunch phase", 128'(phase), 128'd2);
        @(posedge clock);
        #1;
        checkOutput("relaunch start", 128'(aes_start), 128'd1);
        checkOutput("relaunch run", 128'(phase), 128'd3);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("run reset key_out", key_out, 128'h0);
        checkOutput("run reset text_out", text_out, 128'h0);
        checkOutput("run reset phase", 128'(phase), 128'd0);
        checkOutput("run reset start", 128'(aes_start), 128'd0);
        checkOutput("run reset count", 128'(digit_count), 128'd0);
        @(negedge clock);
        reset = 1'b0;
        checkOutput("start pulse total", 128'(start_pulses), 128'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
